// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: consumes DIGIT bits per clock, LSD first,
// with valid/ready handshakes on both the operand and the result side.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic             sub_q;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [DIGIT:0]   dsum;
  logic             c_msb;
  logic [WIDTH-1:0] res_next;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign dsum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + (DIGIT+1)'(carry);
  // Carry into the top bit of the digit; only meaningful on the last digit.
  assign c_msb    = dsum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
  assign res_next = WIDTH'({dsum[DIGIT-1:0], res_sr} >> DIGIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, so an aborted operation
      // leaves no partial state behind and the outputs read zero after reset.
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            // Subtraction is a + ~b + ~cin, so one adder serves both modes.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            sub_q <= sub;
            cnt   <= '0;
            state <= RUN;
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          carry  <= dsum[DIGIT];
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            s     <= res_next;
            co    <= sub_q ^ dsum[DIGIT];
            ovf   <= c_msb ^ dsum[DIGIT];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed table, backpressure and
// reset sequences on DIGIT=4, plus random checks on DIGIT=1/4/16 instances.
module tb_serial_addsub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         ir1, ov1, co1, of1;
  logic         ir4, ov4, co4, of4;
  logic         ir16, ov16, co16, of16;
  logic [W-1:0] s1, s4, s16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
    .s(s4), .co(co4), .ovf(of4)
  );

  serial_addsub #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
    .s(s1), .co(co1), .ovf(of1)
  );

  serial_addsub #(.WIDTH(W), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready),
    .s(s16), .co(co16), .ovf(of16)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a +/- b +/- cin; returns {co, ovf, s}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    int ua, ub, sa, sb, r, sr;
    logic [31:0] rv;
    logic co_m, ovf_m;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!ms) begin
      r    = ua + ub + int'(mc);
      sr   = sa + sb + int'(mc);
      co_m = (r > 65535);
    end else begin
      r    = ua - ub - int'(mc);
      sr   = sa - sb - int'(mc);
      co_m = (r < 0);
    end
    ovf_m = (sr > 32767) || (sr < -32768);
    rv = r;
    return {co_m, ovf_m, rv[W-1:0]};
  endfunction

  task automatic scramble_inputs();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic op4(input vec_t v, input string name);
    int lat;
    logic [W-1:0] prev;
    lat  = 0;
    prev = s4;
    @(negedge clk);
    check({name, " in_ready"}, 32'(ir4), 32'd1);
    in_valid = 1'b1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    check({name, " s held in RUN"}, 32'(s4), 32'(prev));
    while (!ov4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd4);
    check({name, " s"}, 32'(s4), 32'(v.s));
    check({name, " co"}, 32'(co4), 32'(v.co));
    check({name, " ovf"}, 32'(of4), 32'(v.ovf));
  endtask

  task automatic rand_op();
    logic [W-1:0] ra, rb;
    logic rc, rs;
    logic [W+1:0] exp, g1, g4, g16;
    int l1, l4, l16;
    ra = W'($urandom); rb = W'($urandom);
    rc = 1'($urandom); rs = 1'($urandom);
    exp = model(ra, rb, rc, rs);
    l1 = -1; l4 = -1; l16 = -1;
    g1 = 'x; g4 = 'x; g16 = 'x;
    @(negedge clk);
    in_valid = 1'b1;
    a = ra; b = rb; cin = rc; sub = rs;
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ov1 && l1 < 0) begin l1 = k; g1 = {co1, of1, s1}; end
      if (ov4 && l4 < 0) begin l4 = k; g4 = {co4, of4, s4}; end
      if (ov16 && l16 < 0) begin l16 = k; g16 = {co16, of16, s16}; end
    end
    check("rand latency d1", 32'(l1), 32'd16);
    check("rand latency d4", 32'(l4), 32'd4);
    check("rand latency d16", 32'(l16), 32'd1);
    check("rand result d1", 32'(g1), 32'(exp));
    check("rand result d4", 32'(g4), 32'(exp));
    check("rand result d16", 32'(g16), 32'(exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;
    tbl[0] = '{16'h0001, 16'h0003, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    tbl[5] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(ir4), 32'd1);
    check("reset out_valid", 32'(ov4), 32'd0);
    check("reset s/co/ovf", 32'({co4, of4, s4}), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) op4(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: park a result in DONE, then offer new operands.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!ov4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp first latency", 32'(lat), 32'd4);
    in_valid = 1'b1;
    a = 16'h00F0; b = 16'h000F; cin = 1'b1; sub = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp in_ready low", 32'(ir4), 32'd0);
      check("bp out_valid held", 32'(ov4), 32'd1);
      check("bp outputs stable", 32'({co4, of4, s4}), 32'h0002);
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready follows out_ready", 32'(ir4), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    check("bp same-edge handshake", 32'(ov4), 32'd0);
    lat = 0;
    while (!ov4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp second latency", 32'(lat), 32'd4);
    check("bp second s", 32'(s4), 32'h0100);
    check("bp second co/ovf", 32'({co4, of4}), 32'd0);

    // Reset two cycles into RUN
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun reset s/co/ovf", 32'({co4, of4, s4}), 32'd0);
    check("midrun reset out_valid", 32'(ov4), 32'd0);
    check("midrun reset in_ready", 32'(ir4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov4) seen++;
    end
    check("midrun no result after release", 32'(seen), 32'd0);
    check("midrun s stays zero", 32'(s4), 32'd0);

    // Random sweep over DIGIT = 1, 4, 16
    for (int i = 0; i < 1000; i++) rand_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
